// File: rtl/ucsbece154b_mem_arbiter.sv
// rtl/ucsbece154b_mem_arbiter.sv - fetch/data arbiter in front of a shared single-port memory
module ucsbece154b_mem_arbiter #(
   parameter int MEM_AW     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req_i,
   input  logic [MEM_AW-1:0] i_addr_i,
   input  logic              i_flush_i,
   output logic              i_ready_o,
   output logic              i_valid_o,
   output logic [31:0]       i_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [MEM_AW-1:0] d_addr_i,
   input  logic [31:0]       d_wdata_i,
   output logic              d_ready_o,
   output logic              d_valid_o,
   output logic [31:0]       d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i
);
   localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

   typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, I_DROP} state_t;

   state_t            state;
   logic [CW-1:0]     starve_cnt;
   logic [MEM_AW-1:0] addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic              starved;
   logic              data_win;
   logic              fetch_win;
   logic              i_accept;
   logic              d_accept;

   // Data has priority until fetch has watched STARVE_MAX data grants go by.
   always_comb begin
      starved   = i_req_i && (starve_cnt == CW'(STARVE_MAX));
      data_win  = d_req_i && !starved;
      fetch_win = i_req_i && !data_win;
      i_accept  = reset && (state == IDLE) && fetch_win && !i_flush_i;
      d_accept  = reset && (state == IDLE) && data_win;
   end

   assign i_ready_o   = i_accept;
   assign d_ready_o   = d_accept;
   assign i_valid_o   = (state == I_WAIT) && mem_ack_i && !i_flush_i;
   assign i_rdata_o   = i_valid_o ? mem_rdata_i : '0;
   assign d_valid_o   = (state == D_WAIT) && mem_ack_i;
   assign d_rdata_o   = d_valid_o ? mem_rdata_i : '0;
   assign mem_req_o   = (state != IDLE);
   assign mem_we_o    = (state == D_WAIT) && we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_accept) begin
                  state      <= I_WAIT;
                  addr_q     <= i_addr_i;
                  we_q       <= 1'b0;
                  wdata_q    <= '0;
                  starve_cnt <= '0;
               end else if (d_accept) begin
                  state   <= D_WAIT;
                  addr_q  <= d_addr_i;
                  we_q    <= d_we_i;
                  wdata_q <= d_wdata_i;
                  if (i_req_i && (starve_cnt < CW'(STARVE_MAX)))
                     starve_cnt <= starve_cnt + CW'(1);
               end
            end
            // A flushed fetch still owns the memory until its ack drains.
            I_WAIT: begin
               if (mem_ack_i)
                  state <= IDLE;
               else if (i_flush_i)
                  state <= I_DROP;
            end
            D_WAIT: if (mem_ack_i) state <= IDLE;
            I_DROP: if (mem_ack_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// tb/tb_ucsbece154b_mem_arbiter.sv - scoreboard bench for the fetch/data memory arbiter
module tb_ucsbece154b_mem_arbiter;
   localparam int AW = 32;
   localparam byte G_I = 8'h49;
   localparam byte G_D = 8'h44;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req_i, i_flush_i, i_ready_o, i_valid_o;
   logic [AW-1:0] i_addr_i;
   logic [31:0]   i_rdata_o;
   logic          d_req_i, d_we_i, d_ready_o, d_valid_o;
   logic [AW-1:0] d_addr_i;
   logic [31:0]   d_wdata_i, d_rdata_o;
   logic          mem_req_o, mem_we_o, mem_ack_i;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o, mem_rdata_i;

   ucsbece154b_mem_arbiter #(.MEM_AW(AW), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_flush_i(i_flush_i),
      .i_ready_o(i_ready_o), .i_valid_o(i_valid_o), .i_rdata_o(i_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_ready_o(d_ready_o), .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory behind the arbiter, acking ack_delay cycles after mem_req_o rises.
   logic [31:0] mem [logic [31:0]];
   int          ack_delay = 0;
   int          wcnt = 0;
   logic        inject_ack = 1'b0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : init_word(a);
   endfunction

   initial begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
   end

   always @(posedge clk) begin
      #2;
      if (inject_ack) begin
         mem_ack_i   = 1'b1;
         mem_rdata_i = 32'h1234_5678;
      end else if (mem_ack_i) begin
         mem_ack_i   = 1'b0;
         mem_rdata_i = '0;
         wcnt        = 0;
      end else if (mem_req_o) begin
         if (wcnt == ack_delay) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem_rd(mem_addr_o);
            if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   // Scoreboard: reference memory plus expected-result queues filled on accept.
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] iq [$];
   logic [31:0] dq [$];
   bit          dq_st [$];
   byte         grants [$];
   int          dvalid_cnt = 0;
   logic [31:0] mon_exp;
   bit          mon_st;

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_outs", {22'd0, i_ready_o, i_valid_o, d_ready_o, d_valid_o, mem_req_o, mem_we_o,
                          |i_rdata_o, |d_rdata_o, |mem_addr_o, |mem_wdata_o}, 32'd0);
         iq.delete();
         dq.delete();
         dq_st.delete();
      end else begin
         if (i_ready_o) begin
            iq.push_back(ref_rd(i_addr_i));
            grants.push_back(G_I);
         end
         if (d_ready_o) begin
            grants.push_back(G_D);
            if (d_we_i) begin
               ref_mem[d_addr_i] = d_wdata_i;
               dq.push_back(32'd0);
               dq_st.push_back(1'b1);
            end else begin
               dq.push_back(ref_rd(d_addr_i));
               dq_st.push_back(1'b0);
            end
         end
         if (i_valid_o) begin
            chk("i_valid_flush", 32'(i_flush_i), 32'd0);
            if (iq.size() == 0) chk("i_unexpected", iq.size(), 1);
            else chk("i_rdata", i_rdata_o, iq.pop_front());
         end else begin
            chk("i_rdata_zero", i_rdata_o, 32'd0);
            if (i_flush_i && iq.size() > 0) void'(iq.pop_front());
         end
         if (d_valid_o) begin
            dvalid_cnt++;
            if (dq.size() == 0) begin
               chk("d_unexpected", dq.size(), 1);
            end else begin
               mon_exp = dq.pop_front();
               mon_st  = dq_st.pop_front();
               if (!mon_st) chk("d_rdata", d_rdata_o, mon_exp);
            end
         end else begin
            chk("d_rdata_zero", d_rdata_o, 32'd0);
         end
      end
   end

   task automatic do_fetch(input logic [31:0] a, output int acc);
      acc      = -1;
      i_addr_i = a;
      i_req_i  = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (i_ready_o) begin
            acc = cyc;
            break;
         end
      end
      chk("i_accept_timeout", 32'(acc >= 0), 1);
      @(posedge clk); #1;
      i_req_i = 1'b0;
   endtask

   task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int acc);
      acc       = -1;
      d_we_i    = we;
      d_addr_i  = a;
      d_wdata_i = wd;
      d_req_i   = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (d_ready_o) begin
            acc = cyc;
            break;
         end
      end
      chk("d_accept_timeout", 32'(acc >= 0), 1);
      @(posedge clk); #1;
      d_req_i = 1'b0;
      d_we_i  = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   int          c0, c1, vc, ack_c, acc2, dv0, n_acc, v1;
   int          accs [2];
   logic [31:0] vdata;
   byte         exp_g [10];

   initial begin
      reset = 1'b0;
      i_req_i = 1'b0; i_addr_i = '0; i_flush_i = 1'b0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      exp_g = '{G_D, G_D, G_D, G_D, G_I, G_D, G_D, G_D, G_D, G_I};

      // Requests held during reset must not be accepted.
      idle_cycles(2);
      i_req_i = 1'b1; d_req_i = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'({i_ready_o, d_ready_o}), 32'd0);
      chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
      @(posedge clk); #1;
      i_req_i = 1'b0; d_req_i = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      idle_cycles(1);

      // Flush in IDLE only blocks fetch accept for that cycle.
      i_addr_i = 32'h44; i_req_i = 1'b1; i_flush_i = 1'b1;
      @(negedge clk);
      chk("flush_idle_block", 32'(i_ready_o), 32'd0);
      @(posedge clk); #1;
      i_flush_i = 1'b0;
      do_fetch(32'h44, c0);
      idle_cycles(3);

      // Fetch of 0x40 with memory acking two cycles after mem_req_o.
      ack_delay = 2;
      vc = -1;
      do_fetch(32'h40, c0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk("iwait_req", 32'(mem_req_o), 32'd1);
            chk("iwait_we", 32'(mem_we_o), 32'd0);
            chk("iwait_addr", mem_addr_o, 32'h40);
         end
         if (i_valid_o) begin
            vc = cyc;
            vdata = i_rdata_o;
            break;
         end
      end
      chk("fetch_latency", vc - c0, 3);
      chk("fetch_word", vdata, init_word(32'h40));
      idle_cycles(3);

      // Back-to-back loads with zero-wait memory.
      ack_delay = 0;
      n_acc = 0; v1 = -1; accs[0] = -1; accs[1] = -1;
      d_we_i = 1'b0; d_addr_i = 32'h20; d_req_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (d_ready_o) begin
            accs[n_acc] = cyc;
            n_acc++;
         end
         if (d_valid_o && v1 < 0) v1 = cyc;
         if (n_acc == 2) break;
      end
      @(posedge clk); #1;
      d_req_i = 1'b0;
      chk("min_valid_lat", v1 - accs[0], 1);
      chk("min_accept_gap", accs[1] - accs[0], 2);
      idle_cycles(3);

      // Store then load back; flush during D_WAIT must not disturb it.
      ack_delay = 1;
      dv0 = dvalid_cnt;
      do_data(1'b1, 32'h100, 32'hDEAD_BEEF, c0);
      i_flush_i = 1'b1;
      @(negedge clk);
      chk("store_req", 32'(mem_req_o), 32'd1);
      chk("store_we", 32'(mem_we_o), 32'd1);
      chk("store_addr", mem_addr_o, 32'h100);
      chk("store_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      idle_cycles(3);
      i_flush_i = 1'b0;
      chk("store_dvalid_pulses", dvalid_cnt - dv0, 1);
      do_data(1'b0, 32'h100, 32'h0, c1);
      vdata = '0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (d_valid_o) begin
            vdata = d_rdata_o;
            break;
         end
      end
      chk("load_back", vdata, 32'hDEAD_BEEF);
      idle_cycles(3);

      // Both requesters held: fetch gets every fifth grant.
      ack_delay = 0;
      chk("starve_pre", 32'(dut.starve_cnt), 32'd0);
      grants.delete();
      i_addr_i = 32'h200; d_addr_i = 32'h300; d_we_i = 1'b0;
      i_req_i = 1'b1; d_req_i = 1'b1;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (grants.size() >= 10) break;
      end
      @(posedge clk); #1;
      i_req_i = 1'b0; d_req_i = 1'b0;
      chk("grant_count", grants.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < grants.size())
            chk($sformatf("grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
      idle_cycles(4);

      // Flush while the fetch is outstanding; ack lands three cycles later.
      ack_delay = 3;
      ack_c = -1; acc2 = -1;
      do_fetch(32'h60, c0);
      i_flush_i = 1'b1; i_addr_i = 32'h80; i_req_i = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         chk("drop_no_valid", 32'(i_valid_o), 32'd0);
         if (ack_c < 0) chk("drop_req_held", 32'(mem_req_o), 32'd1);
         if (mem_ack_i && ack_c < 0) ack_c = cyc;
         if (i_ready_o) begin
            acc2 = cyc;
            break;
         end
         @(posedge clk); #1;
         i_flush_i = 1'b0;
      end
      @(posedge clk); #1;
      i_req_i = 1'b0;
      chk("drop_ack_seen", 32'(ack_c >= 0), 1);
      chk("refetch_after_ack", acc2 - ack_c, 1);
      idle_cycles(8);

      // Flush coincident with the ack.
      ack_delay = 1;
      do_fetch(32'h64, c0);
      @(posedge clk); #1;
      i_flush_i = 1'b1;
      @(negedge clk);
      chk("coinc_ack", 32'(mem_ack_i), 32'd1);
      chk("coinc_no_valid", 32'(i_valid_o), 32'd0);
      @(posedge clk); #1;
      i_flush_i = 1'b0;
      @(negedge clk);
      chk("coinc_idle", 32'(mem_req_o), 32'd0);
      idle_cycles(2);

      // Reset mid-transaction in D_WAIT, then a stray ack after release.
      ack_delay = 5;
      i_req_i = 1'b1;
      do_data(1'b0, 32'h40, 32'h0, c0);
      @(negedge clk);
      chk("dwait_req", 32'(mem_req_o), 32'd1);
      chk("starve_one", 32'(dut.starve_cnt), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_mid_req", 32'(mem_req_o), 32'd0);
      chk("rst_mid_dvalid", 32'(d_valid_o), 32'd0);
      chk("rst_mid_starve", 32'(dut.starve_cnt), 32'd0);
      @(posedge clk); #1;
      i_req_i = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      inject_ack = 1'b1;
      @(negedge clk);
      chk("stray_ack_seen", 32'(mem_ack_i), 32'd1);
      chk("stray_no_valid", 32'({i_valid_o, d_valid_o}), 32'd0);
      @(posedge clk); #1;
      inject_ack = 1'b0;
      @(negedge clk);
      chk("stray_idle", 32'(mem_req_o), 32'd0);
      idle_cycles(1);

      // Normal traffic resumes after reset.
      ack_delay = 1;
      do_data(1'b0, 32'h100, 32'h0, c0);
      do_fetch(32'h70, c1);
      idle_cycles(6);

      chk("iq_drained", iq.size(), 0);
      chk("dq_drained", dq.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/ucsbece154b_mem_arbiter.md
UCSBECE154B_MEM_ARBITER -- requirements
Module: ucsbece154b_mem_arbiter

Interface
REQ-001 Parameter MEM_AW, default 32, SHALL set the address width.
REQ-002 Parameter STARVE_MAX, default 4, SHALL set the consecutive data grants allowed while fetch waits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 i_req_i  input  1  SHALL be the fetch request, held until accepted.
REQ-006 i_addr_i  input  MEM_AW  SHALL be the fetch address.
REQ-007 i_flush_i  input  1  SHALL be the fetch flush on branch/jump mispredict.
REQ-008 i_ready_o  output  1  SHALL be the fetch accept strobe.
REQ-009 i_valid_o  output  1  SHALL be the fetch data-valid strobe.
REQ-010 i_rdata_o  output  32  SHALL be the fetch instruction word.
REQ-011 d_req_i, d_we_i  input  1 each  SHALL be the data request and write enable, held until accepted.
REQ-012 d_addr_i  input  MEM_AW; d_wdata_i  input  32  SHALL be the data address and write data.
REQ-013 d_ready_o, d_valid_o  output  1 each  SHALL be the data accept strobe and completion strobe.
REQ-014 d_rdata_o  output  32  SHALL be the load data.
REQ-015 mem_req_o, mem_we_o  output  1 each; mem_addr_o  output  MEM_AW; mem_wdata_o  output  32  SHALL drive the shared single-port memory.
REQ-016 mem_ack_i  input  1; mem_rdata_i  input  32  SHALL be the memory completion strobe and read data.

Function
REQ-017 FSM states SHALL be IDLE, I_WAIT, D_WAIT, I_DROP; one memory transaction outstanding at most.
REQ-018 In IDLE, arbitration SHALL be combinational: data wins if d_req_i, unless i_req_i=1 and starve_cnt==STARVE_MAX, in which case fetch wins.
REQ-019 i_ready_o SHALL be 1 only in IDLE when fetch wins and i_flush_i=0; d_ready_o SHALL be 1 only in IDLE when data wins.
REQ-020 On accept, address, we and wdata SHALL be registered; next state I_WAIT or D_WAIT.
REQ-021 mem_req_o SHALL be 1 in I_WAIT, D_WAIT and I_DROP, driven from registered values only; mem_we_o SHALL be 0 outside D_WAIT.
REQ-022 In I_WAIT with mem_ack_i=1, i_valid_o SHALL pulse one cycle with i_rdata_o=mem_rdata_i; state SHALL return to IDLE.
REQ-023 In D_WAIT with mem_ack_i=1, d_valid_o SHALL pulse one cycle (loads and stores); d_rdata_o=mem_rdata_i; state SHALL return to IDLE.
REQ-024 Minimum latency: accept cycle N, mem_req_o in N+1, ack in N+1 gives valid in N+1, next accept no earlier than N+2.
REQ-025 i_flush_i=1 in I_WAIT without ack SHALL move to I_DROP; I_DROP SHALL hold mem_req_o until mem_ack_i, suppress i_valid_o, then go to IDLE.
REQ-026 i_flush_i=1 and mem_ack_i=1 together in I_WAIT SHALL suppress i_valid_o and go to IDLE.
REQ-027 i_flush_i in IDLE or D_WAIT SHALL have no effect other than blocking fetch accept that cycle.
REQ-028 starve_cnt (3 bits min) SHALL increment on a data accept while i_req_i=1, saturate at STARVE_MAX, and clear on any fetch accept.
REQ-029 i_rdata_o/d_rdata_o SHALL be 0 when their valid is 0.
REQ-030 mem_ack_i in IDLE SHALL be ignored.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, starve_cnt=0 and all outputs 0, including mid-transaction; a pending ack after release SHALL be ignored.
REQ-032 After release, the first accept SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-033 Fetch only, addr 0x40, ack 2 cycles after mem_req_o -> i_ready_o cycle 0, i_valid_o in cycle 3, i_rdata_o = mem word at 0x40.
REQ-034 i_req_i and d_req_i held constantly, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-035 Store addr 0x100 data 0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF during D_WAIT, d_valid_o one pulse, then a load of 0x100 returns 0xDEADBEEF.
REQ-036 Flush in I_WAIT, ack 3 cycles later -> mem_req_o held to ack, no i_valid_o, next fetch accepted the cycle after ack.
REQ-037 Flush coincident with ack -> no i_valid_o, state IDLE next cycle.
REQ-038 reset=0 asserted in D_WAIT -> mem_req_o=0 immediately, no d_valid_o, starve_cnt=0.
